hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS datapath. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards against the ID/EX stage, flushes wrong-path instructions on a taken branch, and freezes the pipe while a data-memory access is outstanding, with a timeout.

Parameters:
REG_W, 5, register-specifier width (rs/rt/rd).
MEM_TIMEOUT, 255, maximum wait cycles in MEM_WAIT before abort; legal range 1..65535.
CNT_W, 16, width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
id_rs  in  REG_W  rs of the instruction in ID.
id_rt  in  REG_W  rt of the instruction in ID.
id_uses_rt  in  1  ID instruction reads rt as a source.
ex_load  in  1  ID/EX load flag (instruction in EX is a load).
ex_rt  in  REG_W  ID/EX rt, the load destination.
branch_taken  in  1  branch/jump resolved taken in EX.
mem_req  in  1  EX/MEM stage is issuing a data-memory access.
mem_ready  in  1  data memory completes the access this cycle.
pc_en  out  1  PC register load enable.
ifid_en  out  1  IF/ID register load enable.
ifid_flush  out  1  IF/ID loads a NOP.
idex_en  out  1  ID/EX register load enable.
idex_bubble  out  1  ID/EX loads zeroed control bits (WB, WMEM, load, aluSig).
exmem_en  out  1  EX/MEM register load enable.
memwb_bubble  out  1  MEM/WB loads zeroed WB control.
mem_err  out  1  one-cycle pulse on memory timeout.
stall_cnt  out  32  perf: total stalled cycles (see Optional Feature).
flush_cnt  out  32  perf: total branch flushes (see Optional Feature).

Behaviour:
- The FSM state and wait counter are registered. All control outputs are combinational from the state and the current inputs (Mealy), so a hazard stalls in the same cycle it appears.
- States: RUN, MEM_WAIT.
- While rst=1: state=RUN, counter=0. Outputs are pc_en=0, ifid_en=0, ifid_flush=1, idex_en=1, idex_bubble=1, exmem_en=0, memwb_bubble=1, mem_err=0.
- RUN defaults: pc_en, ifid_en, idex_en and exmem_en are 1. ifid_flush, idex_bubble, memwb_bubble and mem_err are 0.
- Output priority inside RUN, highest first:
  1. Memory stall: mem_req=1 and mem_ready=0. Freeze the pipe: pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, memwb_bubble=1. Next state is MEM_WAIT with counter=1.
  2. Branch: branch_taken=1. pc_en=1 (loads the target), ifid_flush=1, idex_bubble=1. This is a two-instruction penalty taken in a single cycle.
  3. Load-use hazard: ex_load=1 and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)). pc_en=0, ifid_en=0, idex_bubble=1 for exactly one cycle. The load then advances, the hazard disappears and forwarding covers it. No extra state is needed.
- MEM_WAIT: all outputs frozen as in item 1.
  - mem_ready=1: return to RUN next cycle and clear the counter. Outputs in the ready cycle are RUN defaults, so EX/MEM advances.
  - Otherwise, if counter==MEM_TIMEOUT: pulse mem_err=1 and return to RUN. The access is abandoned and memwb_bubble=1 that cycle.
  - Otherwise increment the counter.
- mem_ready with mem_req=0 is ignored.
- branch_taken arriving during MEM_WAIT is not acted on. The EX stage is frozen, so it is re-evaluated in RUN after the wait.
- If branch_taken and the load-use hazard coincide, the branch wins, because the dependent ID instruction is flushed anyway.
- Register 0 never creates a hazard.
- rst asserted mid-MEM_WAIT aborts the wait with no mem_err.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined: stall_cnt increments every cycle in which pc_en=0 and rst=0. flush_cnt increments on every cycle with ifid_flush=1 and rst=0. Both counters wrap modulo 2^32 and are cleared by rst.
- When undefined: no counter registers are built and both ports are tied to 0.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (ST_RUN, ST_MEM_WAIT);
  - the REG_W default;
  - the ZERO_REG constant.
- One natural sub-module: lu_hazard_detect, purely combinational, computing the load-use hit from id_rs, id_rt, id_uses_rt, ex_load and ex_rt.

Test Plan:
- Reset: hold rst 3 cycles -> pc_en=0, ifid_flush=1, idex_bubble=1, memwb_bubble=1. First cycle after release -> all enables 1, no flush.
- Load-use: ex_load=1, ex_rt=5, id_rs=5 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1. With ex_rt=0 and id_rs=0 -> no stall. With id_rt=5 and id_uses_rt=0 -> no stall.
- Branch: branch_taken=1 for one cycle -> ifid_flush=1, idex_bubble=1, pc_en=1. With the load-use condition also true -> same outputs, pc_en stays 1.
- Memory wait: mem_req=1, mem_ready low for 4 cycles then high -> exactly 4 frozen cycles with memwb_bubble=1, exmem_en=1 on the ready cycle, mem_err stays 0.
- Timeout: MEM_TIMEOUT=8, mem_ready never asserted -> mem_err pulses on the 9th stalled cycle and the FSM returns to RUN. rst asserted mid-wait -> RUN with no mem_err.
- Perf (HAZARD_PERF_CNT_EN): the above sequence -> stall_cnt equals the count of pc_en=0 cycles and flush_cnt=1. Without the macro -> both ports 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    localparam int DEF_REG_W = 5;
    localparam int ZERO_REG  = 0;

endpackage

// File: rtl/lu_hazard_detect.sv
// rtl/lu_hazard_detect.sv - combinational load-use hazard detect against the ID/EX load
module lu_hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_load_i,
    input  logic [REG_W-1:0] ex_rt_i,
    output logic             lu_hit_o
);

    logic dest_live;
    logic rs_match;
    logic rt_match;

    // $zero is hardwired, so a load targeting it never produces a value to wait for
    assign dest_live = ex_load_i && (ex_rt_i != REG_W'(ZERO_REG));
    assign rs_match  = (ex_rt_i == id_rs_i);
    assign rt_match  = id_uses_rt_i && (ex_rt_i == id_rt_i);
    assign lu_hit_o  = dest_live && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush/bubble sequencing with memory-wait timeout
// Optional perf counters built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hit;

    lu_hazard_detect #(.REG_W(REG_W)) u_lu_hazard_detect (
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rt_i (id_uses_rt),
        .ex_load_i    (ex_load),
        .ex_rt_i      (ex_rt),
        .lu_hit_o     (lu_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        mem_err      = 1'b0;
        if (rst) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        state_d      = ST_MEM_WAIT;
                        cnt_d        = CNT_W'(1);
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu_hit) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    // The ready cycle releases the freeze so EX/MEM captures the result
                    if (mem_ready) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_en      = 1'b0;
                        exmem_en     = 1'b0;
                        memwb_bubble = 1'b1;
                        if (cnt_q == TIMEOUT_C) begin
                            mem_err = 1'b1;
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en)     stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ifid_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    localparam int REG_W = 5;
    localparam int TO    = 8;

    localparam logic [7:0] O_RST    = 8'b0011_1010;
    localparam logic [7:0] O_RUN    = 8'b1101_0100;
    localparam logic [7:0] O_FREEZE = 8'b0000_0010;
    localparam logic [7:0] O_ERR    = 8'b0000_0011;
    localparam logic [7:0] O_BR     = 8'b1111_1100;
    localparam logic [7:0] O_LU     = 8'b0001_1100;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_load, branch_taken, mem_req, mem_ready;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_bubble;
    logic             exmem_en, memwb_bubble, mem_err;
    logic [31:0]      stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    hazard_stall_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_load      (ex_load),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_bubble  (idex_bubble),
        .exmem_en     (exmem_en),
        .memwb_bubble (memwb_bubble),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble, mem_err};
    endfunction

    // Reference: an access is "outstanding" once it has frozen the pipe; frozen counts
    // how many frozen cycles it has cost so far. The (TO+1)th frozen cycle is the abort.
    bit          outstanding = 1'b0;
    int          frozen      = 0;
    bit          counted     = 1'b0;
    int unsigned m_stall     = 0;
    int unsigned m_flush     = 0;

    function automatic logic [7:0] expect_outs();
        bit hazard;
        hazard = ex_load && (ex_rt != 0) && ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
        if (rst)                               return O_RST;
        if (outstanding && mem_ready)          return O_RUN;
        if (outstanding && frozen == TO)       return O_ERR;
        if (outstanding)                       return O_FREEZE;
        if (mem_req && !mem_ready)             return O_FREEZE;
        if (branch_taken)                      return O_BR;
        if (hazard)                            return O_LU;
        return O_RUN;
    endfunction

    always @(negedge clk) begin
        logic [7:0] e;
        e = expect_outs();
        tests++;
        if (outs() !== e) begin
            fails++;
            $display("FAIL cycle_outputs t=%0t got=%b expected=%b", $time, outs(), e);
        end
        if (counted) begin
            tests++;
`ifdef HAZARD_PERF_CNT_EN
            if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
                fails++;
                $display("FAIL perf_counters t=%0t got=%0d/%0d expected=%0d/%0d",
                         $time, stall_cnt, flush_cnt, m_stall, m_flush);
            end
`else
            if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
                fails++;
                $display("FAIL perf_tied_zero t=%0t got=%0d/%0d expected=0/0",
                         $time, stall_cnt, flush_cnt);
            end
`endif
        end
        if (rst) begin
            outstanding = 1'b0;
            frozen      = 0;
            m_stall     = 0;
            m_flush     = 0;
            counted     = 1'b1;
        end else begin
            if (!e[7]) m_stall++;
            if (e[5])  m_flush++;
            if (outstanding) begin
                if (mem_ready || frozen == TO) begin
                    outstanding = 1'b0;
                    frozen      = 0;
                end else begin
                    frozen++;
                end
            end else if (mem_req && !mem_ready) begin
                outstanding = 1'b1;
                frozen      = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] exp);
        #1;
        tests++;
        if (outs() !== exp) begin
            fails++;
            $display("FAIL %s got=%b expected=%b", name, outs(), exp);
        end
    endtask

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0;
        ex_load = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_hold", O_RST);
            tick();
        end
        rst = 1'b0;
        chk("after_reset", O_RUN);
        tick();

        ex_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        chk("lu_rs_stall", O_LU);
        tick();
        ex_load = 1'b0;
        chk("lu_released", O_RUN);
        tick();
        ex_load = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        chk("lu_zero_reg", O_RUN);
        tick();
        ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
        chk("lu_rt_unused", O_RUN);
        tick();
        id_uses_rt = 1'b1;
        chk("lu_rt_used", O_LU);
        tick();

        ex_load = 1'b0; branch_taken = 1'b1;
        chk("branch", O_BR);
        tick();
        ex_load = 1'b1;
        chk("branch_over_lu", O_BR);
        tick();
        ex_load = 1'b0; branch_taken = 1'b0;

        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("memwait_frozen", O_FREEZE);
            tick();
        end
        mem_ready = 1'b1;
        chk("memwait_ready", O_RUN);
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        chk("memwait_after", O_RUN);
        tick();

        mem_req = 1'b1;
        for (int i = 0; i < TO; i++) begin
            chk("timeout_frozen", O_FREEZE);
            tick();
        end
        chk("timeout_err", O_ERR);
        tick();
        mem_req = 1'b0;
        chk("timeout_back_run", O_RUN);
        tick();

        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_frozen", O_FREEZE);
            tick();
        end
        rst = 1'b1;
        chk("abort_reset", O_RST);
        tick();
        rst = 1'b0; mem_req = 1'b0;
        chk("abort_run", O_RUN);
        tick();

        mem_req = 1'b1;
        chk("br_in_wait_enter", O_FREEZE);
        tick();
        branch_taken = 1'b1;
        chk("br_in_wait_ignored", O_FREEZE);
        tick();
        mem_ready = 1'b1;
        chk("br_in_wait_ready", O_RUN);
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        chk("br_after_wait", O_BR);
        tick();
        branch_taken = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            id_rs        = REG_W'($urandom_range(0, 3));
            id_rt        = REG_W'($urandom_range(0, 3));
            ex_rt        = REG_W'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_load      = ($urandom_range(0, 99) < 40);
            branch_taken = ($urandom_range(0, 99) < 15);
            mem_req      = mem_req ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 15);
            mem_ready    = ($urandom_range(0, 99) < ((i % 500 < 250) ? 30 : 3));
            tick();
        end
        rst = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
